// File: rtl/exp_taylor_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// exp_taylor_engine : e^x (x in Q0.16) as a truncated Taylor series,
//                     one shared 17x17 multiplier, result in Q2.16.
// Revision: 1.0
// ============================================================================
module exp_taylor_engine #(
  parameter int TERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  output logic        busy,
  output logic        done,
  output logic [17:0] result
);

  generate
    if (TERMS < 1 || TERMS > 8) begin : g_bad_terms
      $error("exp_taylor_engine: TERMS must lie in 1..8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL_T = 3'd2,
    S_MUL_C = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]  C_LAST_K = 4'(TERMS);
  localparam logic [16:0] C_ONE_T  = 17'h10000;
  localparam logic [17:0] C_ONE_A  = 18'h10000;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [16:0] term_q, term_d;
  logic [17:0] acc_q, acc_d;
  logic [3:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [17:0] result_q, result_d;

  logic [16:0] w_coef;
  logic [16:0] w_mul_b;
  logic [32:0] w_prod;
  logic [16:0] w_prod_hi;
  logic        w_unused_prod_lsbs;

  // 1/k! in Q1.16
  always_comb begin
    w_coef = 17'h00000;
    case (k_q)
      4'd1:    w_coef = 17'h10000;
      4'd2:    w_coef = 17'h08000;
      4'd3:    w_coef = 17'h02AAB;
      4'd4:    w_coef = 17'h00AAB;
      4'd5:    w_coef = 17'h00222;
      4'd6:    w_coef = 17'h0005B;
      4'd7:    w_coef = 17'h0000D;
      4'd8:    w_coef = 17'h00002;
      default: w_coef = 17'h00000;
    endcase
  end

  // Both products stay below 2^33, so a 33-bit product is exact before truncation.
  assign w_mul_b            = (state_q == S_MUL_T) ? {1'b0, x_q} : w_coef;
  assign w_prod             = 33'(term_q) * 33'(w_mul_b);
  assign w_prod_hi          = w_prod[32:16];
  assign w_unused_prod_lsbs = ^w_prod[15:0];

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    term_d   = term_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        term_d  = C_ONE_T;
        acc_d   = C_ONE_A;
        k_d     = 4'd1;
        state_d = S_MUL_T;
      end
      S_MUL_T: begin
        term_d  = w_prod_hi;
        state_d = S_MUL_C;
      end
      S_MUL_C: begin
        acc_d = acc_q + {1'b0, w_prod_hi};
        if (k_q == C_LAST_K) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_MUL_T;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= 16'h0000;
      term_q   <= 17'h00000;
      acc_q    <= 18'h00000;
      k_q      <= 4'd1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 18'h00000;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
